// File: rtl/ldpc_enc_source.sv
// Frame builder ahead of the LDPC encoder: wraps a payload stream into sop/eop/eof
// framed beats with a latched tag and appends one zero filler word per parity slot.
module ldpc_enc_source #(
  parameter int pDAT_W    = 8,
  parameter int pTAG_W    = 4,
  parameter int pDATA_NUM = 24,
  parameter int pPAR_NUM  = 24
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              ival,
  input  logic [pTAG_W-1:0] itag,
  input  logic [pDAT_W-1:0] idat,
  output logic              ordy,
  input  logic              iencrdy,
  output logic              osop,
  output logic              oeop,
  output logic              oeof,
  output logic              oval,
  output logic [pTAG_W-1:0] otag,
  output logic [pDAT_W-1:0] odat
);

  localparam int CNT_MAX = (pDATA_NUM > pPAR_NUM) ? pDATA_NUM : pPAR_NUM;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(pDATA_NUM - 1);
  localparam logic [CNT_W-1:0] PAR_LAST  = CNT_W'(pPAR_NUM - 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               oval_q, oval_d;
  logic               osop_q, osop_d;
  logic               oeop_q, oeop_d;
  logic               oeof_q, oeof_d;
  logic [pTAG_W-1:0]  otag_q, otag_d;
  logic [pDAT_W-1:0]  odat_q, odat_d;

  logic ld;
  logic xfer;
  logic last_data;
  logic last_par;

  // The output register accepts a new beat when it is empty or being consumed.
  assign ld        = iclkena & (~oval_q | iencrdy);
  assign ordy      = ld & ((state_q == IDLE) | (state_q == DATA));
  assign xfer      = ival & ordy;
  assign last_data = (cnt_q == DATA_LAST);
  assign last_par  = (cnt_q == PAR_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oval_d  = oval_q;
    osop_d  = osop_q;
    oeop_d  = oeop_q;
    oeof_d  = oeof_q;
    otag_d  = otag_q;
    odat_d  = odat_q;
    if (ld) begin
      // Default for a load slot with nothing to send is a bubble; flags drop with it.
      oval_d = 1'b0;
      osop_d = 1'b0;
      oeop_d = 1'b0;
      oeof_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            oval_d  = 1'b1;
            osop_d  = 1'b1;
            odat_d  = idat;
            otag_d  = itag;
            cnt_d   = CNT_W'(1);
            state_d = DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            oval_d = 1'b1;
            odat_d = idat;
            oeop_d = last_data;
            if (last_data) begin
              cnt_d   = '0;
              state_d = PAR;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        PAR: begin
          oval_d = 1'b1;
          odat_d = '0;
          oeof_d = last_par;
          if (last_par) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      oval_q  <= 1'b0;
      osop_q  <= 1'b0;
      oeop_q  <= 1'b0;
      oeof_q  <= 1'b0;
      otag_q  <= '0;
      odat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oval_q  <= oval_d;
      osop_q  <= osop_d;
      oeop_q  <= oeop_d;
      oeof_q  <= oeof_d;
      otag_q  <= otag_d;
      odat_q  <= odat_d;
    end
  end

  assign oval = oval_q;
  assign osop = osop_q;
  assign oeop = oeop_q;
  assign oeof = oeof_q;
  assign otag = otag_q;
  assign odat = odat_q;

endmodule

// File: tb/tb_ldpc_enc_source.sv
// Directed bench for ldpc_enc_source with 4 payload and 3 filler words per frame.
module tb_ldpc_enc_source;

  logic       iclk = 1'b0;
  logic       ireset, iclkena, ival, iencrdy;
  logic [3:0] itag;
  logic [7:0] idat;
  logic       ordy, osop, oeop, oeof, oval;
  logic [3:0] otag;
  logic [7:0] odat;

  int n_vec = 0;
  int n_err = 0;

  ldpc_enc_source #(
    .pDAT_W(8), .pTAG_W(4), .pDATA_NUM(4), .pPAR_NUM(3)
  ) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival),
    .itag(itag), .idat(idat), .ordy(ordy), .iencrdy(iencrdy),
    .osop(osop), .oeop(oeop), .oeof(oeof), .oval(oval),
    .otag(otag), .odat(odat)
  );

  always #5 iclk = ~iclk;

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    $display("%-12s observed %0h expected %0h", name, obs, exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Beat packed as {oval, osop, oeop, oeof, otag, odat}.
  task automatic beat(input string name, input logic v, input logic s, input logic e,
                      input logic f, input logic [3:0] t, input logic [7:0] d);
    chk(name, {16'h0, oval, osop, oeop, oeof, otag, odat}, {16'h0, v, s, e, f, t, d});
  endtask

  initial begin
    ireset = 1'b1; iclkena = 1'b1; ival = 1'b0; iencrdy = 1'b1;
    itag = 4'h0; idat = 8'h00;
    step(); step();
    beat("reset", 0, 0, 0, 0, 4'h0, 8'h00);
    ireset = 1'b0;
    chk("idle_rdy", 32'(ordy), 32'd1);

    // Frame 1: continuous payload, tag only sampled with the first word.
    ival = 1'b1; itag = 4'h5; idat = 8'h01;
    step(); beat("f1_w1", 1, 1, 0, 0, 4'h5, 8'h01);
    itag = 4'h0; idat = 8'h02;
    step(); beat("f1_w2", 1, 0, 0, 0, 4'h5, 8'h02);
    idat = 8'h03;
    step(); beat("f1_w3", 1, 0, 0, 0, 4'h5, 8'h03);
    idat = 8'h04;
    step(); beat("f1_w4", 1, 0, 1, 0, 4'h5, 8'h04);
    idat = 8'hAA;
    chk("par_rdy0", 32'(ordy), 32'd0);
    step(); beat("f1_p1", 1, 0, 0, 0, 4'h5, 8'h00);
    chk("par_rdy1", 32'(ordy), 32'd0);
    step(); beat("f1_p2", 1, 0, 0, 0, 4'h5, 8'h00);
    chk("par_rdy2", 32'(ordy), 32'd0);
    step(); beat("f1_p3", 1, 0, 0, 1, 4'h5, 8'h00);
    ival = 1'b0;
    chk("eof_rdy", 32'(ordy), 32'd1);
    step(); chk("bubble", 32'(oval), 32'd0);

    // Frame 2: encoder drops ready for one cycle after taking the eop beat.
    ival = 1'b1; itag = 4'h6; idat = 8'h11;
    step(); beat("f2_w1", 1, 1, 0, 0, 4'h6, 8'h11);
    idat = 8'h12;
    step(); beat("f2_w2", 1, 0, 0, 0, 4'h6, 8'h12);
    idat = 8'h13;
    step(); beat("f2_w3", 1, 0, 0, 0, 4'h6, 8'h13);
    idat = 8'h14;
    step(); beat("f2_w4", 1, 0, 1, 0, 4'h6, 8'h14);
    ival = 1'b0;
    step(); beat("f2_p1", 1, 0, 0, 0, 4'h6, 8'h00);
    iencrdy = 1'b0;
    step(); beat("f2_p1_hold", 1, 0, 0, 0, 4'h6, 8'h00);
    chk("hold_rdy", 32'(ordy), 32'd0);
    iencrdy = 1'b1;
    step(); beat("f2_p2", 1, 0, 0, 0, 4'h6, 8'h00);
    step(); beat("f2_p3", 1, 0, 0, 1, 4'h6, 8'h00);

    // Frame 3 starts directly after eof, then has payload gaps and a PAR freeze.
    ival = 1'b1; itag = 4'h7; idat = 8'h21;
    chk("b2b_rdy", 32'(ordy), 32'd1);
    step(); beat("f3_w1", 1, 1, 0, 0, 4'h7, 8'h21);
    ival = 1'b0;
    step(); chk("gap1a", 32'(oval), 32'd0);
    step(); chk("gap1b", 32'(oval), 32'd0);
    ival = 1'b1; idat = 8'h22;
    step(); beat("f3_w2", 1, 0, 0, 0, 4'h7, 8'h22);
    ival = 1'b0;
    step(); chk("gap2", 32'(oval), 32'd0);
    ival = 1'b1; idat = 8'h23;
    step(); beat("f3_w3", 1, 0, 0, 0, 4'h7, 8'h23);
    idat = 8'h24;
    step(); beat("f3_w4", 1, 0, 1, 0, 4'h7, 8'h24);
    ival = 1'b0;
    step(); beat("f3_p1", 1, 0, 0, 0, 4'h7, 8'h00);
    step(); beat("f3_p2", 1, 0, 0, 0, 4'h7, 8'h00);
    iclkena = 1'b0;
    chk("ena_rdy", 32'(ordy), 32'd0);
    step(); beat("f3_frz1", 1, 0, 0, 0, 4'h7, 8'h00);
    step(); beat("f3_frz2", 1, 0, 0, 0, 4'h7, 8'h00);
    iclkena = 1'b1;
    step(); beat("f3_p3", 1, 0, 0, 1, 4'h7, 8'h00);
    step(); chk("f3_end", 32'(oval), 32'd0);

    // Frame 4 aborted by reset after word 2; frame 5 must start cleanly.
    ival = 1'b1; itag = 4'h9; idat = 8'h31;
    step(); beat("f4_w1", 1, 1, 0, 0, 4'h9, 8'h31);
    idat = 8'h32;
    step(); beat("f4_w2", 1, 0, 0, 0, 4'h9, 8'h32);
    ireset = 1'b1; ival = 1'b0;
    step(); beat("mid_reset", 0, 0, 0, 0, 4'h0, 8'h00);
    ireset = 1'b0;
    chk("rst_rdy", 32'(ordy), 32'd1);
    ival = 1'b1; itag = 4'hA; idat = 8'h41;
    step(); beat("f5_w1", 1, 1, 0, 0, 4'hA, 8'h41);
    idat = 8'h42;
    step(); beat("f5_w2", 1, 0, 0, 0, 4'hA, 8'h42);
    idat = 8'h43;
    step(); beat("f5_w3", 1, 0, 0, 0, 4'hA, 8'h43);
    idat = 8'h44;
    step(); beat("f5_w4", 1, 0, 1, 0, 4'hA, 8'h44);
    ival = 1'b0;
    step(); beat("f5_p1", 1, 0, 0, 0, 4'hA, 8'h00);
    step(); beat("f5_p2", 1, 0, 0, 0, 4'hA, 8'h00);
    step(); beat("f5_p3", 1, 0, 0, 1, 4'hA, 8'h00);
    step(); chk("f5_end", 32'(oval), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
